mult_div_unit: RTL and testbench

//  Iterative signed 32x32 multiply / 32/32 divide responder for the multicycle

---
 rtl/mult_div_unit.sv | 99 +++++++++
 tb/tb_mult_div_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 multiply / 32/32 divide with HI/LO results
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             MDCtrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done,
   output logic             div0
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t               state, state_nx;
   logic [WIDTH-1:0]     ma, mq, abs_a, abs_b, quo_s, rem_s;
   logic [2*WIDTH-1:0]   acc, prod_s;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH+1:0]     sub_diff;
   logic                 sign_a, sign_b, is_div, go, last, borrow;
   logic [CNTW-1:0]      cnt;

   assign div0   = MDCtrl & (B == '0);
   assign go     = start & ~div0;
   assign last   = cnt == CNTW'(WIDTH - 1);
   assign abs_a  = A[WIDTH-1] ? -A : A;
   assign abs_b  = B[WIDTH-1] ? -B : B;

   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;

   // next state and status outputs
   always_comb begin
      state_nx = state;
      busy     = state != IDLE;
      done     = state == DONE;
      case (state)
         IDLE:    state_nx = go ? CALC : IDLE;
         CALC:    state_nx = last ? FIX : CALC;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   // one iteration of shift-add (MULT) or restoring shift-subtract (DIV), plus sign fix-up
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mq[0] ? {1'b0, ma} : '0);
      sub_diff = {1'b0, acc[2*WIDTH-1:WIDTH], mq[WIDTH-1]} - {2'b0, ma};
      // a non-borrowing difference is below the divisor, so bit WIDTH is only set on borrow
      borrow   = |sub_diff[WIDTH+1:WIDTH];
      prod_s   = (sign_a ^ sign_b) ? -acc : acc;
      quo_s    = (sign_a ^ sign_b) ? -mq : mq;
      rem_s    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // operand latch, iteration datapath and HI/LO result registers
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ma     <= '0;
         mq     <= '0;
         acc    <= '0;
         cnt    <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         is_div <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         case (state)
            IDLE: if (go) begin
               ma     <= abs_b;
               mq     <= abs_a;
               sign_a <= A[WIDTH-1];
               sign_b <= B[WIDTH-1];
               is_div <= MDCtrl;
               acc    <= '0;
               cnt    <= '0;
            end
            CALC: begin
               cnt <= cnt + CNTW'(1);
               if (is_div) begin
                  acc[2*WIDTH-1:WIDTH] <= borrow ? {acc[2*WIDTH-2:WIDTH], mq[WIDTH-1]} : sub_diff[WIDTH-1:0];
                  mq <= {mq[WIDTH-2:0], ~borrow};
               end else begin
                  acc <= {add_sum, acc[WIDTH-1:1]};
                  mq  <= mq >> 1;
               end
            end
            FIX: {HI, LO} <= is_div ? {rem_s, quo_s} : prod_s;
            default: ;
         endcase
      end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized bench with a cycle-level behavioural model of mult_div_unit
module tb_mult_div_unit;
   logic        clk = 0, reset = 0, start = 0, MDCtrl = 0;
   logic [31:0] A = 0, B = 0, HI, LO;
   logic        busy, done, div0;
   int          tests = 0, fails = 0;
   logic        check_en = 0;
   logic        mbusy, edone;
   logic [31:0] ehi, elo, rh, rl;
   int          left;

   mult_div_unit dut (.clk(clk), .reset(reset), .start(start), .MDCtrl(MDCtrl), .A(A), .B(B),
                      .HI(HI), .LO(LO), .busy(busy), .done(done), .div0(div0));

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: 34-edge busy window, results from plain signed 64-bit arithmetic
   always @(posedge clk or negedge reset) begin
      longint sa, sb, p, q, r;
      if (!reset) begin
         mbusy = 0; edone = 0; ehi = 0; elo = 0; left = 0;
      end else if (mbusy) begin
         left--;
         if (left == 1) begin ehi = rh; elo = rl; edone = 1; end
         else if (left == 0) begin mbusy = 0; edone = 0; end
      end else if (start && !(MDCtrl && B == 0)) begin
         mbusy = 1; left = 34;
         sa = longint'($signed(A));
         sb = longint'($signed(B));
         if (MDCtrl) begin
            q = sa / sb; r = sa % sb;
            rl = q[31:0]; rh = r[31:0];
         end else begin
            p = sa * sb;
            rh = p[63:32]; rl = p[31:0];
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) if (check_en) begin
      cmp("div0", div0, MDCtrl && B == 0);
      cmp("busy", busy, mbusy);
      cmp("done", done, edone);
      cmp("HI", HI, ehi);
      cmp("LO", LO, elo);
   end

   task automatic run_op(input logic md, input logic [31:0] a, input logic [31:0] b,
                         input logic lit, input logic [31:0] xh, input logic [31:0] xl);
      int cyc = 0;
      logic got = 0;
      @(posedge clk); #2;
      start = 1; MDCtrl = md; A = a; B = b;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); cyc++; #2;
         if (i < 30) begin
            start = 1'($urandom_range(0, 1)); A = $urandom; B = $urandom; MDCtrl = 1'($urandom_range(0, 1));
         end else start = 0;
         @(negedge clk); got = done;
      end
      start = 0;
      cmp("latency", 64'(cyc), 64'd34);
      if (lit) begin
         cmp("lit_HI", HI, xh);
         cmp("lit_LO", LO, xl);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] sh, sl;
      repeat (3) @(posedge clk);
      #2 reset = 1;
      @(negedge clk);
      check_en = 1;
      cmp("rst_HI", HI, 0); cmp("rst_LO", LO, 0); cmp("rst_busy", busy, 0); cmp("rst_done", done, 0);

      run_op(0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 32'h3FFF_FFFF, 32'h0000_0001);
      run_op(1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op(1, 32'd100, 32'd7, 1, 32'd2, 32'd14);
      run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000);
      run_op(0, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'd0);
      run_op(0, 32'd5, 32'd0, 1, 32'd0, 32'd0);

      // divide by zero request: flagged immediately, never starts, HI/LO untouched
      sh = HI; sl = LO;
      @(posedge clk); #2 start = 1; MDCtrl = 1; A = 32'd123; B = 0;
      @(negedge clk); cmp("div0_flag", div0, 1);
      repeat (4) begin
         @(negedge clk);
         cmp("div0_busy", busy, 0); cmp("div0_done", done, 0);
         cmp("div0_HI", HI, sh); cmp("div0_LO", LO, sl);
      end
      @(posedge clk); #2 start = 0;

      // reset in the middle of an iteration run aborts with no done
      @(posedge clk); #2 start = 1; MDCtrl = 0; A = 32'd9; B = 32'd9;
      @(posedge clk); #2 start = 0;
      repeat (10) @(posedge clk);
      #2 reset = 0;
      @(negedge clk);
      cmp("abort_HI", HI, 0); cmp("abort_LO", LO, 0); cmp("abort_busy", busy, 0);
      @(posedge clk); #2 reset = 1;
      repeat (40) begin
         @(negedge clk); cmp("abort_nodone", done, 0);
      end

      for (int n = 0; n < 150; n++) begin
         logic md;
         logic [31:0] a, b;
         md = 1'($urandom_range(0, 1)); a = pick(); b = pick();
         if (md && b == 0) b = 32'd3;
         run_op(md, a, b, 0, 0, 0);
         if ($urandom_range(0, 9) == 0) begin
            @(posedge clk); #2 start = 1; MDCtrl = 1; B = 0; A = $urandom;
            @(posedge clk); #2 start = 0;
         end
      end

      repeat (3) @(negedge clk);
      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
